// File: rtl/evm_ballot_if.sv
// Ballot-unit bus: presiding-officer / voter inputs and the counter, LED and result outputs.
// The master modport drives the inputs; the ballot controller connects through slave.
interface evm_ballot_if #(
    parameter int CNT_W = 8
);
    logic             issue_ballot;
    logic             close_poll;
    logic [3:0]       btn;
    logic [3:0]       passkey;
    logic             result_req;
    logic             vote_inc;
    logic [1:0]       vote_sel;
    logic [3:0]       led;
    logic             ready_led;
    logic             multi_press;
    logic             timeout;
    logic [CNT_W-1:0] total_votes;
    logic             poll_closed;
    logic             result_grant;

    modport master (
        output issue_ballot, close_poll, btn, passkey, result_req,
        input  vote_inc, vote_sel, led, ready_led, multi_press, timeout,
               total_votes, poll_closed, result_grant
    );

    modport slave (
        input  issue_ballot, close_poll, btn, passkey, result_req,
        output vote_inc, vote_sel, led, ready_led, multi_press, timeout,
               total_votes, poll_closed, result_grant
    );
endinterface

// File: rtl/evm_ballot_ctrl.sv
// One-vote-per-authorisation ballot controller with button edge detection, ballot timeout,
// poll closure and passkey-gated result release. Every output is registered.
module evm_ballot_ctrl #(
    parameter logic [3:0] PASSKEY     = 4'b1010,
    parameter int         TIMEOUT_CYC = 200,
    parameter int         LED_HOLD    = 4,
    parameter int         CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    evm_ballot_if.slave  bus
);

    // One timer serves both the armed-ballot wait and the LED hold.
    localparam int TMR_MAX = (TIMEOUT_CYC > LED_HOLD) ? TIMEOUT_CYC : LED_HOLD;
    localparam int TMR_W   = $clog2(TMR_MAX);

    typedef enum logic [2:0] {IDLE, ARMED, CAST, HOLD, CLOSED} state_t;

    state_t           state, state_nxt;
    logic [3:0]       btn_q;
    logic             close_pend;
    logic [TMR_W-1:0] timer;

    logic [3:0]       rise;
    logic             press_ok, press_multi, armed_done, hold_done;
    logic [1:0]       btn_idx;

    logic             vote_inc_q, vote_inc_d;
    logic [1:0]       vote_sel_q, vote_sel_d;
    logic [3:0]       led_q, led_d;
    logic             ready_q, ready_d;
    logic             multi_q, multi_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             closed_q, closed_d;
    logic             grant_q, grant_d;

    always_comb begin
        rise        = bus.btn & ~btn_q;
        press_ok    = (|rise) && $onehot(bus.btn);
        press_multi = (|rise) && !$onehot(bus.btn);
        armed_done  = (timer == TMR_W'(TIMEOUT_CYC - 1));
        hold_done   = (timer == TMR_W'(LED_HOLD - 1));
        case (bus.btn)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            btn_q      <= '0;
            close_pend <= 1'b0;
            timer      <= '0;
        end else begin
            state <= state_nxt;
            btn_q <= bus.btn;
            if (bus.close_poll && state != IDLE && state != CLOSED)
                close_pend <= 1'b1;
            if (state_nxt != state)
                timer <= '0;
            else if (state == ARMED || state == HOLD)
                timer <= timer + TMR_W'(1);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.close_poll || close_pend) state_nxt = CLOSED;
                else if (bus.issue_ballot)        state_nxt = ARMED;
            end
            ARMED: begin
                if (press_ok)        state_nxt = CAST;
                else if (armed_done) state_nxt = IDLE;
            end
            CAST:    state_nxt = HOLD;
            HOLD:    if (hold_done) state_nxt = IDLE;
            CLOSED:  state_nxt = CLOSED;
            default: state_nxt = IDLE;
        endcase
    end

    // Output values are derived from the transition so they line up with the new state.
    always_comb begin
        vote_inc_d = (state == ARMED) && (state_nxt == CAST);
        vote_sel_d = vote_inc_d ? btn_idx : vote_sel_q;
        if (vote_inc_d)
            led_d = bus.btn;
        else if (state_nxt == CAST || state_nxt == HOLD)
            led_d = led_q;
        else
            led_d = '0;
        ready_d   = (state_nxt == ARMED) || (state_nxt == CAST) || (state_nxt == HOLD);
        multi_d   = (state == ARMED) && press_multi;
        timeout_d = (state == ARMED) && (state_nxt == IDLE);
        total_d   = (state == CAST && total_q != '1) ? total_q + CNT_W'(1) : total_q;
        closed_d  = (state_nxt == CLOSED);
        grant_d   = (state == CLOSED) && bus.result_req && (bus.passkey == PASSKEY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_inc_q <= 1'b0;
            vote_sel_q <= '0;
            led_q      <= '0;
            ready_q    <= 1'b0;
            multi_q    <= 1'b0;
            timeout_q  <= 1'b0;
            total_q    <= '0;
            closed_q   <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            vote_inc_q <= vote_inc_d;
            vote_sel_q <= vote_sel_d;
            led_q      <= led_d;
            ready_q    <= ready_d;
            multi_q    <= multi_d;
            timeout_q  <= timeout_d;
            total_q    <= total_d;
            closed_q   <= closed_d;
            grant_q    <= grant_d;
        end
    end

    assign bus.vote_inc     = vote_inc_q;
    assign bus.vote_sel     = vote_sel_q;
    assign bus.led          = led_q;
    assign bus.ready_led    = ready_q;
    assign bus.multi_press  = multi_q;
    assign bus.timeout      = timeout_q;
    assign bus.total_votes  = total_q;
    assign bus.poll_closed  = closed_q;
    assign bus.result_grant = grant_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Self-checking bench for evm_ballot_ctrl: expected votes are queued as presses are driven
// and matched against each vote_inc strobe; totals and pulses are checked against a model.
module tb_evm_ballot_ctrl;

    localparam int LED_HOLD    = 4;
    localparam int TIMEOUT_CYC = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    evm_ballot_if #(.CNT_W(8)) bus ();

    evm_ballot_ctrl #(
        .PASSKEY(4'b1010), .TIMEOUT_CYC(TIMEOUT_CYC), .LED_HOLD(LED_HOLD), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int total_exp = 0;
    int vote_cnt[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {12'd0, bus.vote_inc, bus.vote_sel, bus.led, bus.ready_led, bus.multi_press,
                bus.timeout, bus.total_votes, bus.poll_closed, bus.result_grant};
    endfunction

    // Scoreboard consumer: each strobe must match the oldest queued press.
    always @(negedge clk) begin
        int e;
        if (bus.vote_inc) begin
            if (exp_q.size() == 0) begin
                check("vote_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("vote_sel", 32'(bus.vote_sel), 32'(e));
                check("vote_led", 32'(bus.led), 32'(1 << e));
                vote_cnt[bus.vote_sel]++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.issue_ballot = 1'b0;
        bus.close_poll   = 1'b0;
        bus.btn          = '0;
        bus.passkey      = '0;
        bus.result_req   = 1'b0;
        tick(2);
        check("reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        total_exp = 0;
        for (int i = 0; i < 4; i++) vote_cnt[i] = 0;
    endtask

    task automatic arm();
        bus.issue_ballot = 1'b1;
        tick(1);
        bus.issue_ballot = 1'b0;
        check("arm_ready", 32'(bus.ready_led), 32'd1);
    endtask

    // One-cycle press on an armed ballot; returns at the first IDLE cycle.
    task automatic press_valid(input int idx);
        bus.btn = 4'(1 << idx);
        exp_q.push_back(idx);
        if (total_exp < 255) total_exp++;
        tick(1);
        bus.btn = '0;
        check("cast_inc", 32'(bus.vote_inc), 32'd1);
        tick(LED_HOLD);
        check("hold_led", 32'(bus.led), 32'(1 << idx));
        tick(1);
        check("idle_led", 32'(bus.led), 32'd0);
        check("idle_ready", 32'(bus.ready_led), 32'd0);
        check("total", 32'(bus.total_votes), 32'(total_exp));
    endtask

    task automatic cast_vote(input int idx);
        arm();
        press_valid(idx);
    endtask

    initial begin
        int seq[9] = '{0, 1, 1, 1, 1, 1, 2, 3, 0};

        do_reset();

        // Single vote for candidate 1.
        cast_vote(1);

        // Multi-press rejected, ballot stays armed, later valid press counts.
        arm();
        bus.btn = 4'b0101;
        tick(1);
        check("multi_pulse", 32'(bus.multi_press), 32'd1);
        check("multi_ready", 32'(bus.ready_led), 32'd1);
        check("multi_noinc", 32'(bus.vote_inc), 32'd0);
        bus.btn = '0;
        tick(1);
        check("multi_clear", 32'(bus.multi_press), 32'd0);
        press_valid(3);

        // Button held across arming yields no vote until re-pressed.
        bus.btn = 4'b0001;
        tick(2);
        arm();
        tick(3);
        check("held_ready", 32'(bus.ready_led), 32'd1);
        check("held_total", 32'(bus.total_votes), 32'(total_exp));
        bus.btn = '0;
        tick(1);
        press_valid(0);

        // Timeout after exactly TIMEOUT_CYC armed cycles.
        arm();
        tick(TIMEOUT_CYC - 1);
        check("to_early", 32'(bus.timeout), 32'd0);
        check("to_still_armed", 32'(bus.ready_led), 32'd1);
        tick(1);
        check("to_pulse", 32'(bus.timeout), 32'd1);
        check("to_ready", 32'(bus.ready_led), 32'd0);
        tick(1);
        check("to_clear", 32'(bus.timeout), 32'd0);
        check("to_total", 32'(bus.total_votes), 32'(total_exp));

        // Nine-vote sequence, then close and result gating.
        do_reset();
        foreach (seq[i]) cast_vote(seq[i]);
        check("cnt_bjp", 32'(vote_cnt[0]), 32'd2);
        check("cnt_jdu", 32'(vote_cnt[1]), 32'd5);
        check("cnt_rjd", 32'(vote_cnt[2]), 32'd1);
        check("cnt_inc", 32'(vote_cnt[3]), 32'd1);
        check("total9", 32'(bus.total_votes), 32'd9);
        bus.close_poll = 1'b1;
        tick(1);
        bus.close_poll = 1'b0;
        check("closed", 32'(bus.poll_closed), 32'd1);
        bus.result_req = 1'b1;
        bus.passkey    = 4'b0000;
        tick(1);
        check("grant_badkey", 32'(bus.result_grant), 32'd0);
        bus.passkey = 4'b1010;
        tick(1);
        check("grant_key", 32'(bus.result_grant), 32'd1);
        bus.result_req = 1'b0;
        tick(1);
        check("grant_drop", 32'(bus.result_grant), 32'd0);
        bus.issue_ballot = 1'b1;
        bus.btn          = 4'b0010;
        tick(2);
        bus.issue_ballot = 1'b0;
        bus.btn          = '0;
        tick(2);
        check("closed_ready", 32'(bus.ready_led), 32'd0);
        check("closed_total", 32'(bus.total_votes), 32'd9);
        check("closed_stays", 32'(bus.poll_closed), 32'd1);

        // Close requested during HOLD: ballot completes, CLOSED on the following IDLE cycle.
        do_reset();
        arm();
        bus.btn = 4'b0001;
        exp_q.push_back(0);
        total_exp++;
        tick(1);
        bus.btn = '0;
        check("ch_inc", 32'(bus.vote_inc), 32'd1);
        tick(1);
        bus.close_poll = 1'b1;
        tick(1);
        bus.close_poll = 1'b0;
        tick(3);
        check("ch_idle_open", 32'(bus.poll_closed), 32'd0);
        check("ch_total", 32'(bus.total_votes), 32'd1);
        tick(1);
        check("ch_closed", 32'(bus.poll_closed), 32'd1);

        // Reset while armed aborts the ballot.
        do_reset();
        arm();
        tick(3);
        rst = 1'b1;
        tick(1);
        check("rst_armed", all_outs(), 32'd0);
        rst = 1'b0;
        tick(1);
        check("rst_after", all_outs(), 32'd0);

        // Counter saturation at all-ones.
        do_reset();
        for (int i = 0; i < 256; i++) cast_vote(i % 4);
        check("saturate", 32'(bus.total_votes), 32'd255);

        tick(2);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
